// File: rtl/accum_pkg.sv
// Shared types and constants for the sample accumulator bank.
//   accum_state_e : controller states (IDLE, ACCUM, DRAIN)
//   DEF_*         : default parameter values
//   idx_w()       : index width for an n-entry space, never below 1 bit
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } accum_state_e;

  localparam int unsigned DEF_DW     = 4;
  localparam int unsigned DEF_AW     = 11;
  localparam int unsigned DEF_ROWS   = 2;
  localparam int unsigned DEF_COLS   = 4;
  localparam int unsigned DEF_FRAMES = 3;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational saturating adder: acc + zero-extended din, clamped to 2^AW-1.
//   acc : current accumulator value (AW bits)
//   din : unsigned sample (DW bits, DW <= AW)
//   sum : saturated result (AW bits)
//   ovf : high when the true sum exceeded 2^AW-1
module sat_add #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 4
) (
  input  logic [AW-1:0] acc,
  input  logic [DW-1:0] din,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  // One extra bit catches the carry out of the accumulator range.
  logic [AW:0] full;

  assign full = {1'b0, acc} + (AW+1)'(din);
  assign ovf  = full[AW];
  assign sum  = ovf ? {AW{1'b1}} : full[AW-1:0];

endmodule

// File: rtl/sample_accum_bank.sv
// Accumulates a sample stream into a ROWS x COLS bank of saturating
// accumulators over FRAMES full passes, then drains the bank one entry per
// valid/ready handshake in row-major order.
//   clk, rst              : clock, asynchronous active-high reset
//   start, clr            : leave IDLE / synchronous clear to IDLE
//   in_valid/in_ready     : sample handshake, in_data sample
//   out_valid/out_ready   : drain handshake, out_idx/out_data entry
//   frame_done            : one-cycle pulse after the final drain beat
//   sat_seen              : sticky saturation flag
module sample_accum_bank
  import accum_pkg::*;
#(
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned FRAMES = DEF_FRAMES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           clr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DW-1:0]                  in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [idx_w(ROWS*COLS)-1:0]    out_idx,
  output logic [AW-1:0]                  out_data,
  output logic                           frame_done,
  output logic                           sat_seen
);

  localparam int unsigned N      = ROWS * COLS;
  localparam int unsigned IDX_W  = idx_w(N);
  localparam int unsigned ROW_W  = idx_w(ROWS);
  localparam int unsigned COL_W  = idx_w(COLS);
  localparam int unsigned PASS_W = idx_w(FRAMES);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(FRAMES - 1);

  accum_state_e state, next_state;

  logic [IDX_W-1:0]  wr_ptr, rd_ptr;
  logic [PASS_W-1:0] pass;
  logic [AW-1:0]     bank [ROWS][COLS];

  logic [ROW_W-1:0]  wr_row, rd_row;
  logic [COL_W-1:0]  wr_col, rd_col;
  logic [AW-1:0]     add_sum;
  logic              add_ovf;
  logic              accept, drain_fire, wr_last, rd_last;

  // Flat row-major pointers split into bank coordinates.
  assign wr_row = ROW_W'(wr_ptr / IDX_W'(COLS));
  assign wr_col = COL_W'(wr_ptr % IDX_W'(COLS));
  assign rd_row = ROW_W'(rd_ptr / IDX_W'(COLS));
  assign rd_col = COL_W'(rd_ptr % IDX_W'(COLS));

  assign accept     = in_valid && in_ready;
  assign drain_fire = out_valid && out_ready;
  assign wr_last    = (wr_ptr == LAST_IDX);
  assign rd_last    = (rd_ptr == LAST_IDX);

  sat_add #(
    .AW (AW),
    .DW (DW)
  ) u_sat_add (
    .acc (bank[wr_row][wr_col]),
    .din (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; clr overrides every other transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (accept && wr_last && (pass == LAST_PASS)) next_state = DRAIN;
      DRAIN:   if (drain_fire && rd_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (clr) next_state = IDLE;
  end

  // Handshake and drain outputs; data/index read as zero outside DRAIN.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_data  = '0;
    case (state)
      ACCUM: in_ready = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        out_idx   = rd_ptr;
        out_data  = bank[rd_row][rd_col];
      end
      default: ;
    endcase
  end

  // Bank, pointers, pass counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          bank[r][c] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass       <= '0;
      sat_seen   <= 1'b0;
      frame_done <= 1'b0;
    end else if (clr) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          bank[r][c] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass       <= '0;
      sat_seen   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= drain_fire && rd_last;
      if (accept) begin
        bank[wr_row][wr_col] <= add_sum;
        if (add_ovf) sat_seen <= 1'b1;
        wr_ptr <= wr_last ? '0 : wr_ptr + IDX_W'(1);
        if (wr_last) pass <= (pass == LAST_PASS) ? '0 : pass + PASS_W'(1);
      end
      // Drained entries are zeroed so the next run starts from a clean bank.
      if (drain_fire) begin
        bank[rd_row][rd_col] <= '0;
        rd_ptr <= rd_last ? '0 : rd_ptr + IDX_W'(1);
      end
    end
  end

  // An accepted sample must carry known data.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && in_ready) assert (!$isunknown(in_data));
  end

endmodule

// File: tb/tb_sample_accum_bank.sv
module tb_sample_accum_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready, out_valid, frame_done, sat_seen;
  logic [2:0] out_idx;
  logic [10:0] out_data;

  logic       s_start = 1'b0, s_clr = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [3:0] s_in_data = '0;
  logic       s_in_ready, s_out_valid, s_frame_done, s_sat_seen;
  logic [2:0] s_out_idx;
  logic [4:0] s_out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sample_accum_bank dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .frame_done(frame_done), .sat_seen(sat_seen)
  );

  sample_accum_bank #(.AW(5)) dut5 (
    .clk(clk), .rst(rst), .start(s_start), .clr(s_clr),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_idx(s_out_idx),
    .out_data(s_out_data), .frame_done(s_frame_done), .sat_seen(s_sat_seen)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Samples 1..8 for three passes, optionally with idle gaps between accepts.
  task automatic feed_frames(input bit gaps);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 8; i++) begin
        if (gaps) begin
          in_valid = 1'b0;
          in_data  = 'x;
          repeat ($urandom_range(0, 3)) step();
        end
        in_valid = 1'b1;
        in_data  = 4'(i + 1);
        step();
      end
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  // Full-speed drain expecting base + mult*(idx+1) at each index.
  task automatic drain_check(input string tag, input int base, input int mult);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_idx"}, 32'(out_idx), 32'(i));
      check({tag, "_data"}, 32'(out_data), 32'(base + mult * (i + 1)));
      step();
    end
    check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    step();
    check({tag, "_frame_done_pulse"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    // Reset values.
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_sat_seen", 32'(sat_seen), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Basic three-pass accumulation and drain.
    do_start();
    feed_frames(1'b0);
    check("s1_drain_entry_valid", 32'(out_valid), 32'd1);
    check("s1_drain_entry_ready", 32'(in_ready), 32'd0);
    drain_check("s1", 0, 3);

    // Backpressured drain with X data presented on an ignored input.
    do_start();
    feed_frames(1'b0);
    in_valid = 1'b1;
    in_data  = 'x;
    for (int i = 0; i < 8; i++) begin
      check("bp_idx", 32'(out_idx), 32'(i));
      check("bp_data", 32'(out_data), 32'(3 * (i + 1)));
      out_ready = 1'b0;
      step();
      check("bp_stall_idx", 32'(out_idx), 32'(i));
      check("bp_stall_data", 32'(out_data), 32'(3 * (i + 1)));
      out_ready = 1'b1;
      step();
    end
    check("bp_frame_done", 32'(frame_done), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();

    // clr after five accepts, then a clean run of 2s.
    do_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'd7;
      step();
    end
    in_valid = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_in_ready", 32'(in_ready), 32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    do_start();
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1;
      in_data  = 4'd2;
      step();
    end
    in_valid = 1'b0;
    drain_check("clr2", 6, 0);

    // Asynchronous reset mid-drain.
    do_start();
    feed_frames(1'b0);
    out_ready = 1'b1;
    repeat (3) step();
    check("mid_idx", 32'(out_idx), 32'd3);
    check("mid_data", 32'(out_data), 32'd12);
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_idx", 32'(out_idx), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_start();
    feed_frames(1'b0);
    drain_check("post_rst", 0, 3);
    check("post_rst_sat", 32'(sat_seen), 32'd0);

    // Random idle gaps between accepts.
    do_start();
    feed_frames(1'b1);
    drain_check("gaps", 0, 3);

    // Saturation on the narrow-accumulator instance.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 8; i++) begin
        s_in_valid = 1'b1;
        s_in_data  = 4'd15;
        step();
        if (p == 1 && i == 7) check("sat_not_yet", 32'(s_sat_seen), 32'd0);
      end
    s_in_valid = 1'b0;
    check("sat_seen_set", 32'(s_sat_seen), 32'd1);
    check("sat_drain_valid", 32'(s_out_valid), 32'd1);
    s_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("sat_idx", 32'(s_out_idx), 32'(i));
      check("sat_data", 32'(s_out_data), 32'd31);
      step();
    end
    s_out_ready = 1'b0;
    check("sat_frame_done", 32'(s_frame_done), 32'd1);
    check("sat_sticky", 32'(s_sat_seen), 32'd1);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    check("sat_cleared", 32'(s_sat_seen), 32'd0);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = 4'd1;
      step();
    end
    s_in_valid = 1'b0;
    check("sat_clean_flag", 32'(s_sat_seen), 32'd0);
    s_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("sat_clean_data", 32'(s_out_data), 32'd3);
      step();
    end
    s_out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_accum_bank.md
# sample_accum_bank

Downstream consumer of the 4-bit sample stream driven by the basic read/write bench. It accumulates incoming samples into a ROWS×COLS bank of AW-bit saturating accumulators over FRAMES full passes. It then drains the bank one entry per handshake to the next stage. It is the first real DUT for the nicotb read/write flow, exercising valid/ready handshakes, array state and X-gated inputs.

## Interface
- `DW`, default 4: input sample width.
- `AW`, default 11: accumulator width.
- `ROWS`, default 2: bank rows.
- `COLS`, default 4: bank columns.
- `FRAMES`, default 3: full passes accumulated before drain.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: leaves IDLE.
- `clr` in 1: synchronous clear.
- `in_valid` in 1: sample valid.
- `in_ready` out 1: sample accept.
- `in_data` in DW: sample, zero-extended.
- `out_valid` out 1: drain entry valid.
- `out_ready` in 1: downstream accept.
- `out_idx` out clog2(ROWS*COLS): row-major index, row*COLS+col.
- `out_data` out AW: entry value.
- `frame_done` out 1: one-cycle pulse after the last drain beat.
- `sat_seen` out 1: sticky saturation flag.

## Operation
- States are IDLE, ACCUM and DRAIN. Reset enters IDLE.
- Reset clears all entries, `wr_ptr`, `rd_ptr`, `pass` and `sat_seen`.
- Output values during reset:
  - `in_ready` = 0
  - `out_valid` = 0
  - `out_idx` = 0
  - `out_data` = 0
  - `frame_done` = 0
  - `sat_seen` = 0
- IDLE → ACCUM on `start`=1 at the clock edge.
- ACCUM:
  - `in_ready`=1.
  - On `in_valid && in_ready`, `entry[wr_ptr]` ← sat(`entry[wr_ptr]` + `in_data`).
  - `wr_ptr` increments and wraps from ROWS*COLS-1 to 0.
  - On wrap, `pass` increments.
  - The wrap with `pass`==FRAMES-1 moves the state to DRAIN and resets `pass` to 0.
- sat(): the sum is computed in AW+1 bits.
  - A result above 2^AW-1 clamps to 2^AW-1 and sets `sat_seen`.
  - `sat_seen` stays set until `rst` or `clr`.
- DRAIN:
  - `in_ready`=0 and `out_valid`=1.
  - `out_idx`=`rd_ptr`; `out_data`=`entry[rd_ptr]`.
  - On `out_valid && out_ready`, `entry[rd_ptr]` ← 0 and `rd_ptr` increments.
  - After the beat for index ROWS*COLS-1: `rd_ptr`←0, state → IDLE, `frame_done`=1 for exactly the next cycle.
- `clr`=1 in any state:
  - Clears entries, pointers, `pass` and `sat_seen`; state → IDLE.
  - Takes priority over accept, drain and `start` in the same cycle.
- Outside ACCUM, `in_valid` is ignored.
- `in_data` is don't-care (X allowed) while `in_valid`=0. X on `in_data` with `in_valid`=1 is illegal and flagged by assertion.
- `out_data`/`out_idx` hold 0 when `out_valid`=0.

## Timing
- `in_ready`, `out_valid`, `out_idx` and `out_data` are combinational from registered state, pointers and bank. There is no combinational path from `in_valid`/`out_ready` to any output.
- An accept at edge N is visible in `entry` and `wr_ptr` after edge N.
- The final ACCUM accept at edge N gives `out_valid`=1 in cycle N+1 and `in_ready`=0 in the same cycle.
- Drain takes minimum ROWS*COLS cycles with `out_ready` held 1. Backpressure holds `out_idx`/`out_data` stable.
- `frame_done` is registered and appears the cycle after the last drain handshake, concurrent with IDLE.
- Asynchronous `rst` mid-ACCUM or mid-DRAIN returns all outputs to reset values immediately. No partial drain resumes.

## Structure
- Package `accum_pkg` holds:
  - the state enum `accum_state_e` (IDLE, ACCUM, DRAIN);
  - default parameter constants;
  - the `IDX_W` localparam function.
- Sub-module `sat_add` (parameterised AW/DW) is a combinational saturating adder returning sum and overflow flag. It is instantiated once on the `wr_ptr` entry.
- Bank storage is a 2-D unpacked array `[ROWS][COLS]` of AW bits, dumped with `+mda`.

## Test plan
- Reset, `start`, feed samples 1..8 three times (FRAMES=3) → drain outputs idx 0..7 = 3,6,9,12,15,18,21,24, `frame_done` one cycle after idx 7, state IDLE.
- AW=5: feed 15 at every slot for 3 passes → entries 31 (clamped at 45→31), `sat_seen`=1. `clr` → `sat_seen`=0, entries 0.
- During DRAIN, toggle `out_ready` 1/0 → each idx appears once in order and `out_data` is stable while stalled. Drive `in_valid`=1 with `in_data`=X during DRAIN → no entry changes.
- `clr` after 5 accepts in ACCUM → `in_ready`=0 next cycle, all entries 0. `start`, then 24 samples of value 2 → all drain values 6.
- Assert `rst` mid-drain at idx 3 → outputs 0 immediately. After release and `start`, a full run gives clean results with no stale entries.
- `in_valid`=0 gaps of random length between accepts → same results as the first scenario.
